// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit: fetches into the instruction register, sequences
// load/store through a req/ack memory port and pulses datapath clock enables.
module cpu_sequencer #(
  parameter int WAIT_MAX    = 15,
  parameter int SRST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        load,
  input  logic        store,
  input  logic        halt_cmd,
  input  logic        rst_cmd,
  output logic [15:0] ir,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        pc_en,
  output logic        rf_en,
  output logic        alu_en,
  output logic        soft_reset,
  output logic        halted,
  output logic        mem_error,
  output logic [15:0] retired,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_SRST   = 3'd7
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);
  localparam logic [7:0] SRST_LAST = 8'(SRST_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] retired_q, retired_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  srst_q, srst_d;
  logic        mem_error_q, mem_error_d;
  logic        ld_q, ld_d;
  logic        st_q, st_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      retired_q   <= '0;
      wait_q      <= '0;
      srst_q      <= '0;
      mem_error_q <= 1'b0;
      ld_q        <= 1'b0;
      st_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      retired_q   <= retired_d;
      wait_q      <= wait_d;
      srst_q      <= srst_d;
      mem_error_q <= mem_error_d;
      ld_q        <= ld_d;
      st_q        <= st_d;
    end
  end

  // Memory handshake: mem_req stays high for the whole access; the access
  // completes in the cycle mem_ack is high (one-cycle pulse, rdata valid then).
  // The wait counter restarts on each entry to FETCH/MEM and faults to HALT.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    retired_d   = retired_q;
    wait_d      = wait_q;
    srst_d      = srst_q;
    mem_error_d = mem_error_q;
    ld_d        = ld_q;
    st_d        = st_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d     = S_HALT;
          mem_error_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        ld_d = load;
        st_d = store;
        if (halt_cmd) begin
          state_d = S_HALT;
        end else if (rst_cmd) begin
          state_d = S_SRST;
          srst_d  = '0;
        end else if (load || store) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        retired_d = retired_q + 16'd1;
        state_d   = S_FETCH;
        wait_d    = '0;
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d     = S_HALT;
          mem_error_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        retired_d = retired_q + 16'd1;
        state_d   = S_FETCH;
        wait_d    = '0;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      S_SRST: begin
        if (srst_q == SRST_LAST) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end else begin
          srst_d = srst_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decode; the load/store flavour is latched in DECODE so no input
  // reaches an output combinationally.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    pc_en        = 1'b0;
    rf_en        = 1'b0;
    alu_en       = 1'b0;
    soft_reset   = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_FETCH: mem_req = 1'b1;
      S_EXEC: begin
        alu_en = 1'b1;
        rf_en  = 1'b1;
        pc_en  = 1'b1;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = st_q;
        alu_en       = 1'b1;
      end
      S_WB: begin
        pc_en = 1'b1;
        rf_en = ld_q;
      end
      S_HALT:  halted     = 1'b1;
      S_SRST:  soft_reset = 1'b1;
      default: ;
    endcase
  end

  assign ir        = ir_q;
  assign retired   = retired_q;
  assign mem_error = mem_error_q;
  assign state     = state_q;

endmodule
